serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, one bit per clock with a borrow flip-flop.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic             load;
  logic             step;
  logic             finish;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full-subtractor bit cell
  always_comb begin
    d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next = {d_bit, res_sr[WIDTH-1:1]};
  end

  // Operand/result shift registers; visible outputs update only on load and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (load) begin
      a_sr       <= a;
      b_sr       <= b;
      res_sr     <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb      <= a[WIDTH-1];
      b_msb      <= b[WIDTH-1];
      ovf        <= 1'b0;
`endif
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      br     <= br_next;
      count  <= count + CW'(1);
      if (finish) begin
        diff       <= res_next;
        borrow_out <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        // Final bit computed is the result MSB
        ovf        <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic/timeline model plus directed literal vectors.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a_in),
    .b          (b_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles elapsed since acceptance (0 = idle); result appears at WIDTH+1
  int           m_cnt;
  logic [W-1:0] m_diff, p_diff;
  logic         m_bo, p_bo, m_ovf, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_diff = '0; m_bo = 1'b0; m_ovf = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = 1;
        m_diff = '0; m_bo = 1'b0; m_ovf = 1'b0;
        p_diff = W'(a_in - b_in);
        p_bo   = (a_in < b_in);
        p_ovf  = (a_in[W-1] != b_in[W-1]) && (p_diff[W-1] != a_in[W-1]);
      end
    end else begin
      m_cnt++;
      if (m_cnt == W + 1) begin
        m_diff = p_diff; m_bo = p_bo; m_ovf = p_ovf;
      end else if (m_cnt == W + 2) begin
        m_cnt = 0;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("done", 32'(done), 32'(m_cnt == W + 1));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("borrow_out", 32'(borrow_out), 32'(m_bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    if (done === 1'b1) done_seen++;
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = ~a; b_in = ~b;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic ebo);
    start_op(a, b);
    chk({name, "_busy_next"}, 32'(busy), 32'd1);
    wait_done();
    chk({name, "_diff"}, 32'(diff), 32'(ed));
    chk({name, "_borrow"}, 32'(borrow_out), 32'(ebo));
    chk({name, "_model"}, 32'(m_diff), 32'(ed));
    @(negedge clk);
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
    chk({name, "_hold"}, 32'(diff), 32'(ed));
  endtask

  int d0;
  int lat;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: done appears exactly WIDTH cycles after the first busy cycle
    start_op(8'h05, 8'h03);
    lat = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(W));
    chk("sub05_03", 32'(diff), 32'h02);
    chk("sub05_03_bo", 32'(borrow_out), 32'd0);
    @(negedge clk);
    chk("busy_low_after_done", 32'(busy), 32'd0);

    run_op("sub03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
    run_op("sub00_00", 8'h00, 8'h00, 8'h00, 1'b0);
    run_op("subFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("sub00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("sub5A_C3", 8'h5A, 8'hC3, 8'h97, 1'b1);

    // start while busy is ignored
    d0 = done_seen;
    start_op(8'h10, 8'h01);
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_diff", 32'(diff), 32'h0F);
    chk("ignore_borrow", 32'(borrow_out), 32'd0);
    chk("ignore_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("ignore_one_done", 32'(done_seen - d0), 32'd1);

    // Asynchronous reset mid-operation
    start_op(8'h20, 8'h10);
    repeat (4) @(negedge clk);
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_diff", 32'(diff), 32'd0);
    chk("async_borrow", 32'(borrow_out), 32'd0);
    repeat (12) @(negedge clk);
    chk("async_no_done", 32'(done_seen - d0), 32'd0);
    rst_n = 1'b1;
    run_op("sub09_04", 8'h09, 8'h04, 8'h05, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op("ovf80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
    chk("ovf80_01_ovf", 32'(ovf), 32'd1);
    run_op("ovf7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1);
    chk("ovf7F_FF_ovf", 32'(ovf), 32'd1);
    run_op("ovf05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    chk("ovf05_03_ovf", 32'(ovf), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
